// File: rtl/pix_block_feeder_if.sv
// -----------------------------------------------------------------------------
// pix_block_feeder_if
// Bundles the ROM read port and the downstream pixel stream of the block
// feeder.
//   master : the feeder. It drives rom_rd, rom_addr, pix_data, pix_valid and
//            block_start, and receives rom_q and pix_ready.
//   slave  : the ROM plus the pixel consumer.
// Parameter AW is the raster pixel address width.
// -----------------------------------------------------------------------------
interface pix_block_feeder_if #(
  parameter int AW = 11
);
  logic          rom_rd;       // ROM read strobe
  logic [AW-1:0] rom_addr;     // raster pixel address
  logic [7:0]    rom_q;        // ROM data, one cycle after rom_rd
  logic [7:0]    pix_data;     // pixel in 8x8 block order
  logic          pix_valid;    // pix_data holds a pixel
  logic          pix_ready;    // consumer accepts
  logic          block_start;  // pix_data is pixel 0 of a block

  modport master (
    output rom_rd, rom_addr, pix_data, pix_valid, block_start,
    input  rom_q, pix_ready
  );

  modport slave (
    input  rom_rd, rom_addr, pix_data, pix_valid, block_start,
    output rom_q, pix_ready
  );
endinterface

// File: rtl/pix_block_feeder.sv
// -----------------------------------------------------------------------------
// pix_block_feeder
// Reads a raster-ordered image from a ROM that has one cycle of read latency.
// Emits the image as a stream of 8x8 blocks: blocks in raster order, and
// pixels in raster order within each block.
//
// Ports
//   clk    : clock; all state changes happen on its rising edge
//   reset  : asynchronous, active-low reset
//   start  : begins one frame when the feeder is idle
//   bus    : pix_block_feeder_if.master (ROM port and pixel stream)
//   busy   : a frame is in progress
//   done   : one-cycle pulse after the final pixel of a frame is transferred
//
// Build option
//   PIX_FEED_CONTINUOUS_EN : after the last read of a frame, the feeder wraps
//   to address 0 and keeps running without a new start. done still pulses once
//   per frame, and busy stays high.
// -----------------------------------------------------------------------------
module pix_block_feeder #(
  parameter int IMG_W_BLK = 8,
  parameter int IMG_H_BLK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  pix_block_feeder_if.master    bus,
  output logic                  busy,
  output logic                  done
);

  localparam int AW  = $clog2(IMG_W_BLK * IMG_H_BLK * 64);
  localparam int BXW = $clog2(IMG_W_BLK);
  localparam int BYW = $clog2(IMG_H_BLK);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] rd_cnt;       // block-order read index {by, bx, row, col}
  logic [AW-1:0] out_cnt;      // transfers made in the current frame
  logic          rd_pend;      // a ROM read returns this cycle
  logic          rd_pend_bs;   // that read is pixel 0 of a block
  logic [7:0]    fifo_pix [2];
  logic          fifo_bs  [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    occ;
  logic          xfer, last_rd, last_xfer;
  logic [2:0]    in_use;

  // Read order walks col, row, bx, by. The ROM is raster ordered, so the
  // block-column and pixel-row fields swap places in the address.
  assign bus.rom_addr = {rd_cnt[6+BXW +: BYW], rd_cnt[5:3],
                         rd_cnt[6 +: BXW], rd_cnt[2:0]};

  assign xfer      = bus.pix_valid & bus.pix_ready;
  assign last_rd   = (rd_cnt == '1);
  assign last_xfer = xfer && (out_cnt == '1);

  // Slots already claimed: FIFO entries plus the returning read. A pixel that
  // leaves this cycle frees its slot at once, so the stream can run at one
  // pixel per cycle with at most two pixels in the loop.
  assign in_use     = 3'(occ) + 3'(rd_pend) - 3'(xfer);
  assign bus.rom_rd = (state == RUN) && (in_use < 3'd2);

  assign bus.pix_valid   = (occ != 2'd0);
  assign bus.pix_data    = fifo_pix[rd_ptr];
  assign bus.block_start = fifo_bs[rd_ptr] & bus.pix_valid;
  assign busy            = (state != IDLE);

  // NOTE: always_comb assigns a default to every output first, so that no path
  // leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
`ifdef PIX_FEED_CONTINUOUS_EN
      RUN:   state_nxt = RUN;
`else
      RUN:   if (bus.rom_rd && last_rd) state_nxt = DRAIN;
`endif
      DRAIN: if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      out_cnt    <= '0;
      rd_pend    <= 1'b0;
      rd_pend_bs <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pend    <= bus.rom_rd;
      rd_pend_bs <= (rd_cnt[5:0] == 6'd0);
      done       <= last_xfer;
      // Both counters wrap to zero at the end of a frame, which leaves them
      // ready for the next frame.
      if (bus.rom_rd) rd_cnt  <= rd_cnt + AW'(1);
      if (xfer)       out_cnt <= out_cnt + AW'(1);
    end
  end

  // NOTE: the two FIFO entries are reset along with the control logic, because
  // pix_data and block_start are read straight from the head entry and must
  // come out of reset as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_pix[0] <= 8'd0;
      fifo_pix[1] <= 8'd0;
      fifo_bs[0]  <= 1'b0;
      fifo_bs[1]  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (rd_pend) begin
        fifo_pix[wr_ptr] <= bus.rom_q;
        fifo_bs[wr_ptr]  <= rd_pend_bs;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(rd_pend) - 2'(xfer);
    end
  end

endmodule

// File: tb/tb_pix_block_feeder.sv
// -----------------------------------------------------------------------------
// tb_pix_block_feeder
// Scoreboard bench for pix_block_feeder at the default 8x4-block geometry.
//
// The ROM model returns ROM[a] = a[7:0] one cycle after each read. Each time a
// frame is started, the expected block-order stream is pushed into a queue.
// That stream is computed from block and pixel coordinates. A monitor pops the
// queue on every transfer. The monitor also checks that outputs hold steady
// during stalls, that the done pulse and busy are correct, and that no more
// than two pixels are ever outstanding.
// -----------------------------------------------------------------------------
module tb_pix_block_feeder;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int AW     = 11;
  localparam int NPIX   = W * H * 64;
  localparam int BOUND  = 20000;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  pix_block_feeder_if #(.AW(AW)) bus ();

  pix_block_feeder #(.IMG_W_BLK(W), .IMG_H_BLK(H)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // ROM with one cycle of read latency.
  initial bus.rom_q = 8'd0;
  always @(posedge clk) if (bus.rom_rd) bus.rom_q <= bus.rom_addr[7:0];

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];       // {block_start, pixel}
  int   xfer_cnt  = 0;
  int   issued    = 0;
  int   taken     = 0;
  int   stall_cnt = 0;
  bit   rand_ready = 0;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixel k of a frame, derived from block and pixel coordinates.
  function automatic logic [8:0] exp_pix(input int k);
    int blk, p, bx, by, row, col, addr;
    blk  = k / 64;
    p    = k % 64;
    bx   = blk % W;
    by   = blk / W;
    row  = p / 8;
    col  = p % 8;
    addr = ((by * 8 + row) * W + bx) * 8 + col;
    return {(p == 0), 8'(addr % 256)};
  endfunction

  task automatic push_frame();
    for (int k = 0; k < NPIX; k++) exp_q.push_back(exp_pix(k));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rom_rd"},   bus.rom_rd == 1'b0,      bus.rom_rd,      0);
    check({name, "_rom_addr"}, bus.rom_addr == '0,      bus.rom_addr,    0);
    check({name, "_pix_data"}, bus.pix_data == 8'd0,    bus.pix_data,    0);
    check({name, "_valid"},    bus.pix_valid == 1'b0,   bus.pix_valid,   0);
    check({name, "_bstart"},   bus.block_start == 1'b0, bus.block_start, 0);
    check({name, "_busy"},     busy == 1'b0,            busy,            0);
    check({name, "_done"},     done == 1'b0,            done,            0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < BOUND && !seen; i++) begin
      @(posedge clk); #1;
      seen = done;
    end
    check(name, seen, seen, 1);
  endtask

  task automatic wait_xfer(input string name, input int n);
    for (int i = 0; i < BOUND && xfer_cnt < n; i++) @(negedge clk);
    check(name, xfer_cnt >= n, xfer_cnt, n);
  endtask

  // Ready driver: changes pix_ready just after each rising edge.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        bus.pix_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        bus.pix_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.pix_ready = 1'b1;
      end
    end
  end

  // Monitor: samples at the falling edge and judges the coming rising edge.
  initial begin
    bit         prev_stall = 0;
    bit         done_due   = 0;
    logic [8:0] prev_out   = '0;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 0;
        done_due   = 0;
      end else begin
        if (prev_stall)
          check("stall_hold",
                bus.pix_valid && {bus.block_start, bus.pix_data} == prev_out,
                {bus.pix_valid, bus.block_start, bus.pix_data}, {1'b1, prev_out});
        if (done || done_due) begin
          check("done_pulse", done == done_due, done, done_due);
`ifndef PIX_FEED_CONTINUOUS_EN
          if (done) check("busy_low_at_done", busy == 1'b0, busy, 0);
`endif
        end
        done_due = 0;
        if (bus.pix_valid && bus.pix_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 1'b0, bus.pix_data, 0);
          end else begin
            exp = exp_q.pop_front();
            check("pixel", {busy, bus.block_start, bus.pix_data} == {1'b1, exp},
                  {busy, bus.block_start, bus.pix_data}, {1'b1, exp});
          end
          xfer_cnt++;
          taken++;
          if (xfer_cnt % NPIX == 0) done_due = 1;
        end
        if (bus.rom_rd) begin
          issued++;
          check("outstanding", (issued - taken) <= 2, issued - taken, 2);
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_out   = {bus.block_start, bus.pix_data};
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1 reset = 1'b1;

    // Frame A, pix_ready high: start-to-valid latency, then the full stream.
    push_frame();
`ifdef PIX_FEED_CONTINUOUS_EN
    push_frame();
`endif
    pulse_start();
    check("busy_after_start", busy == 1'b1, busy, 1);
    @(negedge clk);
    check("lat_valid_e0", bus.pix_valid == 1'b0, bus.pix_valid, 0);
    @(negedge clk);
    check("lat_valid_e1", bus.pix_valid == 1'b0, bus.pix_valid, 0);
    @(negedge clk);
    check("lat_valid_e2", bus.pix_valid == 1'b1, bus.pix_valid, 1);

`ifdef PIX_FEED_CONTINUOUS_EN
    // Two back-to-back frames with no new start, then stop with reset.
    wait_xfer("cont_two_frames", 2 * NPIX);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    xfer_cnt = 0; issued = 0; taken = 0;
    @(negedge clk);
    check_reset_vals("cont_reset");
`else
    wait_done("frame_a_done");

    // Frame B starts in the done cycle. pix_ready is random, with a 20-cycle
    // stall at pixel 100.
    push_frame();
    rand_ready = 1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_xfer("frame_b_px100", NPIX + 100);
    stall_cnt = 20;
    wait_done("frame_b_done");
    rand_ready = 0;

    // Frame C: reset at pixel 300, then a fresh frame.
    push_frame();
    pulse_start();
    wait_xfer("frame_c_px300", 2 * NPIX + 300);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    xfer_cnt = 0; issued = 0; taken = 0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    @(posedge clk); #1 reset = 1'b1;
    push_frame();
    pulse_start();
    wait_done("frame_d_done");
    @(negedge clk);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pix_block_feeder.md
PIX_BLOCK_FEEDER -- requirements
Module: pix_block_feeder

Interface
REQ-001 SHALL have parameter IMG_W_BLK, default 8: image width in 8x8 blocks, power of two.
REQ-002 SHALL have parameter IMG_H_BLK, default 4: image height in 8x8 blocks, power of two.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin one frame when idle.
REQ-006 SHALL have port rom_rd, output, 1 bit: image ROM read strobe.
REQ-007 SHALL have port rom_addr, output, log2(IMG_W_BLK*IMG_H_BLK*64) bits (11 at defaults): raster pixel address.
REQ-008 SHALL have port rom_q, input, 8 bits: ROM data, valid the cycle after rom_rd is sampled.
REQ-009 SHALL have port pix_data, output, 8 bits: pixel in 8x8 block order.
REQ-010 SHALL have port pix_valid, output, 1 bit: pix_data holds a pixel.
REQ-011 SHALL have port pix_ready, input, 1 bit: downstream accepts; a transfer occurs on an edge with pix_valid and pix_ready both high.
REQ-012 SHALL have port block_start, output, 1 bit: qualifies pix_data as pixel 0 of a block.
REQ-013 SHALL have port busy, output, 1 bit: frame in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on start; RUN->DRAIN after the last ROM read issues; DRAIN->IDLE on the last pixel transfer.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL scan blocks in raster order (bx fastest, then by) and pixels within a block in raster order (col fastest, then row).
REQ-018 SHALL drive rom_addr = {by, row, bx, col}; this is the concatenation of block row, pixel row, block column and pixel column.
REQ-019 SHALL buffer ROM returns in a 2-entry FIFO carrying {block_start flag, pixel}.
REQ-020 SHALL assert rom_rd only in RUN and only when FIFO occupancy + reads in flight - (transfer this cycle) < 2; rom_addr SHALL advance only on an issued read.
REQ-021 SHALL hold pix_valid high and keep pix_data and block_start stable while pix_ready is low.
REQ-022 SHALL make pix_valid first high after the 2nd rising edge following the edge that samples start.
REQ-023 SHALL sustain one transfer per cycle with pix_ready held high.
REQ-024 SHALL never overflow the FIFO, drop a pixel or duplicate a pixel under any pix_ready pattern.
REQ-025 SHALL pulse done for one cycle, starting the cycle after the final (IMG_W_BLK*IMG_H_BLK*64-th) transfer.
REQ-026 SHALL drive busy high from the cycle after start is sampled until done is high; busy SHALL be low while done is high.
REQ-027 SHALL accept a start asserted in the done cycle, since the state is already IDLE then.

Reset
REQ-028 SHALL on reset low, at any time including mid-frame, clear the state to IDLE, clear all counters and the FIFO, and drop in-flight reads.
REQ-029 SHALL hold these reset values: rom_rd=0, rom_addr=0, pix_data=0, pix_valid=0, block_start=0, busy=0, done=0.

Configuration
REQ-030 SHALL, with macro PIX_FEED_CONTINUOUS_EN defined, restart from address 0 after the final read without a new start; done then pulses per frame, busy stays high, and there is no bubble between frames with pix_ready high.
REQ-031 SHALL, without PIX_FEED_CONTINUOUS_EN, run exactly one frame per start.

Verification
REQ-032 SHALL pass: ROM[a]=a[7:0], pix_ready=1, start pulse -> pixels 0..9 = 00,01,..07,40,41; pixel 64 = 08 with block_start=1; done one cycle after the 2048th transfer.
REQ-033 SHALL pass: same ROM, block 8 (by=1,bx=0) first pixel -> address 512, value 00, block_start=1.
REQ-034 SHALL pass: pix_ready random 50% -> received stream identical to the REQ-032 stream, pix_data stable during every stall, never more than 2 reads outstanding.
REQ-035 SHALL pass: pix_ready low for 20 cycles at pixel 100 -> rom_rd stops after occupancy reaches 2 and the stream resumes with pixel 100 unchanged.
REQ-036 SHALL pass: reset low at pixel 300, then start -> outputs at reset values, then a fresh frame beginning at pixel value 00, block_start=1.
REQ-037 SHALL pass: with PIX_FEED_CONTINUOUS_EN, pix_ready=1 -> transfer 2049 has value 00 with block_start=1, and done pulses every 2048 transfers.
